sccb_init_seq: RTL and testbench

Camera register-initialisation sequencer for the OV2640 path. On a start pulse it waits a power-up interval, then walks a {register, value} table held in an external synchronous ROM and issues one SCCB write per entry to the SCCB_CTRL master through a request/done handshake. It retries NACKed writes, inserts a bus-free gap between writes, and reports busy/done/error status to the system controller.

---
 rtl/sccb_init_seq_if.sv | 28 ++
 rtl/sccb_init_seq.sv | 164 ++++++++++++++++
 tb/tb_sccb_init_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_seq_if.sv
// Bundle between the init sequencer, its table ROM, the SCCB write master and the
// system controller. master = sequencer side, slave = environment side.
interface sccb_init_seq_if #(
  parameter int unsigned AW = 8
) ();
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          sccb_req;
  logic [7:0]    sccb_id;
  logic [7:0]    sccb_reg;
  logic [7:0]    sccb_wdata;
  logic          sccb_done;
  logic          sccb_nack;

  modport master (
    input  start, tbl_data, sccb_done, sccb_nack,
    output busy, done, err, tbl_addr, sccb_req, sccb_id, sccb_reg, sccb_wdata
  );

  modport slave (
    output start, tbl_data, sccb_done, sccb_nack,
    input  busy, done, err, tbl_addr, sccb_req, sccb_id, sccb_reg, sccb_wdata
  );
endinterface

// File: rtl/sccb_init_seq.sv
// OV2640 register-initialisation sequencer: walks a {reg,val} ROM and issues SCCB writes
// with NACK retry and inter-write gap. Define SEQ_DELAY_EN to treat reg 8'hFE as a delay.
module sccb_init_seq #(
  parameter logic [7:0]  DEV_ID     = 8'h60,
  parameter int unsigned TBL_LEN    = 64,
  parameter int unsigned AW         = 8,
  parameter logic [15:0] PWRUP_CYC  = 16'd1000,
  parameter logic [7:0]  GAP_CYC    = 8'd16,
  parameter int unsigned MAX_RETRY  = 2,
  parameter logic [15:0] DELAY_UNIT = 16'd1000
) (
  input logic            XCLK,
  input logic            RST,
  sccb_init_seq_if.master bus
);

  localparam logic [AW-1:0] LastIdx = AW'(TBL_LEN - 1);

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StFetch,
    StWaitRom,
    StIssue,
    StWaitDone,
    StGap,
`ifdef SEQ_DELAY_EN
    StDelay,
`endif
    StFinish
  } state_e;

  state_e        state;
  logic [AW-1:0] idx;
  logic [15:0]   cnt;
  logic [7:0]    retry;
  logic          ok;
`ifdef SEQ_DELAY_EN
  logic [23:0]   dly;
`endif

  assign bus.sccb_id = DEV_ID;

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      state          <= StIdle;
      idx            <= '0;
      cnt            <= '0;
      retry          <= '0;
      ok             <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.sccb_req   <= 1'b0;
      bus.tbl_addr   <= '0;
      bus.sccb_reg   <= '0;
      bus.sccb_wdata <= '0;
`ifdef SEQ_DELAY_EN
      dly            <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            state    <= StPwrup;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            idx      <= '0;
            retry    <= '0;
            cnt      <= '0;
          end
        end
        StPwrup: begin
          if (PWRUP_CYC == 16'd0 || cnt == PWRUP_CYC - 16'd1) begin
            state        <= StFetch;
            bus.tbl_addr <= idx;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // ROM samples tbl_addr at the end of this cycle
        StFetch: state <= StWaitRom;
        StWaitRom: begin
          bus.sccb_reg   <= bus.tbl_data[15:8];
          bus.sccb_wdata <= bus.tbl_data[7:0];
`ifdef SEQ_DELAY_EN
          if (bus.tbl_data[15:8] == 8'hFE) begin
            state <= StDelay;
            dly   <= {16'd0, bus.tbl_data[7:0]} * {8'd0, DELAY_UNIT};
          end else begin
            state <= StIssue;
          end
`else
          state <= StIssue;
`endif
        end
        StIssue: begin
          bus.sccb_req <= 1'b1;
          state        <= StWaitDone;
        end
        StWaitDone: begin
          if (bus.sccb_done) begin
            bus.sccb_req <= 1'b0;
            cnt          <= '0;
            if (!bus.sccb_nack) begin
              retry <= '0;
              ok    <= 1'b1;
              state <= StGap;
            end else if (retry == 8'(MAX_RETRY)) begin
              bus.err <= 1'b1;
              state   <= StFinish;
            end else begin
              retry <= retry + 8'd1;
              ok    <= 1'b0;
              state <= StGap;
            end
          end
        end
        // GAP_CYC+1 cycles here between the done pulse and the next fetch
        StGap: begin
          if (cnt == {8'd0, GAP_CYC}) begin
            if (ok && idx == LastIdx) begin
              state <= StFinish;
            end else begin
              state <= StFetch;
              if (ok) begin
                idx          <= idx + 1'b1;
                bus.tbl_addr <= idx + 1'b1;
              end else begin
                bus.tbl_addr <= idx;
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef SEQ_DELAY_EN
        StDelay: begin
          if (dly == 24'd0) begin
            retry <= '0;
            if (idx == LastIdx) begin
              state <= StFinish;
            end else begin
              state        <= StFetch;
              idx          <= idx + 1'b1;
              bus.tbl_addr <= idx + 1'b1;
            end
          end else begin
            dly <= dly - 24'd1;
          end
        end
`endif
        StFinish: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: directed scenarios plus randomized tables, checked against an
// entry-level timing/transaction model.
module tb_sccb_init_seq;
  localparam int unsigned TBL_LEN   = 3;
  localparam int unsigned AW        = 8;
  localparam int unsigned MAX_RETRY = 2;
  localparam int          PWRUP     = 10;
  localparam int          GAP       = 16;
  localparam int          DUNIT     = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  sccb_init_seq_if #(.AW(AW)) bus ();

  sccb_init_seq #(
    .DEV_ID    (8'h60),
    .TBL_LEN   (TBL_LEN),
    .AW        (AW),
    .PWRUP_CYC (16'(PWRUP)),
    .GAP_CYC   (8'(GAP)),
    .MAX_RETRY (MAX_RETRY),
    .DELAY_UNIT(16'(DUNIT))
  ) dut (
    .XCLK(clk),
    .RST (rst),
    .bus (bus)
  );

  logic [15:0] rom [TBL_LEN];
  int          lat = 20;
  logic [7:0]  nack_reg = 8'h00;
  int          nack_cnt = 0;
  int          nack_left = 0;
  int          wcnt = 0;
  logic        req_prev = 1'b0;
  logic        done_prev = 1'b0;
  int          done_time = -1;
  int          max_addr = 0;
  int          s_cyc = 0;
  int          writes_q[$];
  int          req_q[$];
  int          exp_w[$];
  int          exp_req[$];
  int          exp_total;
  int          exp_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous table ROM
  initial forever begin
    @(posedge clk);
    bus.tbl_data <= (int'(bus.tbl_addr) < TBL_LEN) ? rom[bus.tbl_addr[1:0]] : 16'h0000;
  end

  // SCCB slave responder and observer, both away from the active edge
  initial forever begin
    @(negedge clk);
    if (int'(bus.tbl_addr) > max_addr) max_addr = int'(bus.tbl_addr);
    if (bus.sccb_req && !req_prev) req_q.push_back(cyc);
    req_prev = bus.sccb_req;
    if (bus.done && !done_prev) done_time = cyc;
    done_prev = bus.done;
    bus.sccb_done = 1'b0;
    bus.sccb_nack = 1'b0;
    if (bus.sccb_req) begin
      wcnt++;
      if (wcnt == lat) begin
        bus.sccb_done = 1'b1;
        if (bus.sccb_reg == nack_reg && nack_left > 0) begin
          bus.sccb_nack = 1'b1;
          nack_left--;
        end
        writes_q.push_back(int'({bus.sccb_id, bus.sccb_reg, bus.sccb_wdata}));
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-entry model: FETCH at f, req at f+3, done pulse at f+3+lat
  task automatic build_model(input int lat_i);
    int f, i, nl, tries;
    logic [7:0] r, v;
    exp_w.delete();
    exp_req.delete();
    exp_err = 0;
    exp_total = 0;
    f = PWRUP;
    nl = nack_cnt;
    i = 0;
    tries = 0;
    while (i < int'(TBL_LEN)) begin
      r = rom[i][15:8];
      v = rom[i][7:0];
`ifdef SEQ_DELAY_EN
      if (r == 8'hFE) begin
        if (i == int'(TBL_LEN) - 1) begin
          exp_total = f + int'(v) * DUNIT + 4;
          break;
        end
        f += int'(v) * DUNIT + 3;
        i++;
        continue;
      end
`endif
      exp_w.push_back(int'({8'h60, r, v}));
      exp_req.push_back(f + 3);
      if (r == nack_reg && nl > 0) begin
        nl--;
        tries++;
        if (tries > int'(MAX_RETRY)) begin
          exp_err = 1;
          exp_total = f + lat_i + 4;
          break;
        end
        f += lat_i + GAP + 4;
      end else begin
        tries = 0;
        if (i == int'(TBL_LEN) - 1) begin
          exp_total = f + lat_i + GAP + 5;
          break;
        end
        f += lat_i + GAP + 4;
        i++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int lat_i, input bit inj);
    int inj_wait;
    bit injd;
    inj_wait = 0;
    injd = 1'b0;
    lat = lat_i;
    nack_left = nack_cnt;
    writes_q.delete();
    req_q.delete();
    done_time = -1;
    max_addr = 0;
    build_model(lat_i);
    @(negedge clk);
    bus.start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    for (int k = 0; k < 20000 && done_time < 0; k++) begin
      @(negedge clk);
      if (inj && !injd && writes_q.size() == 1) begin
        if (inj_wait == 5) begin
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
          injd = 1'b1;
          check({tag, "_busy_after_start_in_gap"}, 32'(bus.busy), 32'd1);
          check({tag, "_done_after_start_in_gap"}, 32'(bus.done), 32'd0);
        end else begin
          inj_wait++;
        end
      end
    end
    if (done_time < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_nwrites"}, 32'(writes_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < writes_q.size() && i < exp_w.size(); i++)
      check($sformatf("%s_write%0d", tag, i), 32'(writes_q[i]), 32'(exp_w[i]));
    for (int i = 0; i < req_q.size() && i < exp_req.size(); i++)
      check($sformatf("%s_req_time%0d", tag, i), 32'(req_q[i] - s_cyc), 32'(exp_req[i]));
    check({tag, "_done_time"}, 32'(done_time - s_cyc), 32'(exp_total));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, 32'(bus.sccb_req), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_addr"}, 32'(bus.tbl_addr), 32'd0);
    check({tag, "_reg"}, 32'(bus.sccb_reg), 32'd0);
    check({tag, "_wdata"}, 32'(bus.sccb_wdata), 32'd0);
    check({tag, "_id"}, 32'(bus.sccb_id), 32'h60);
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.sccb_done = 1'b0;
    bus.sccb_nack = 1'b0;
    rom[0] = 16'hFF01;
    rom[1] = 16'h1280;
    rom[2] = 16'h3C32;
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_seq("normal", 20, 1'b0);

    nack_reg = 8'h12;
    nack_cnt = 1;
    run_seq("nack_recover", 20, 1'b0);

    do_reset();
    nack_reg = 8'hFF;
    nack_cnt = 99;
    run_seq("nack_abort", 20, 1'b0);
    check("nack_abort_no_fetch1", 32'(max_addr), 32'd0);

    // Reset while a write is outstanding, then restart from entry 0
    nack_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = bus.sccb_req;
    end
    check("rst_mid_req_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_seq("after_rst", 20, 1'b0);

    run_seq("start_in_gap", 20, 1'b1);

    rom[0] = 16'h1280;
    rom[1] = 16'hFE05;
    rom[2] = 16'h3C32;
    run_seq("delay", 20, 1'b0);
`ifdef SEQ_DELAY_EN
    if (req_q.size() >= 2)
      check("delay_quiet", 32'(req_q[1] - req_q[0] >= 500), 32'd1);
    else
      check("delay_req_count", 32'(req_q.size()), 32'd2);
`endif

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < int'(TBL_LEN); i++) begin
        rom[i] = 16'($urandom);
        if (rom[i][15:8] == 8'hFE) rom[i][15:8] = 8'h11;
      end
      nack_reg = rom[$urandom_range(0, TBL_LEN - 1)][15:8];
      nack_cnt = $urandom_range(0, 3);
      do_reset();
      run_seq($sformatf("rand%0d", t), $urandom_range(1, 30), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
